// File: rtl/neuron_frame_loader_pkg.sv
// Shared definitions for the neuron input interface.
// Holds the pixel width, the pixels-per-frame count and the derived beat
// counter width, so that the frame loader and the neuron consumer agree on
// how the Image/Weight buses are packed.
package neuron_frame_loader_pkg;

    localparam int size_word    = 8;
    localparam int number_image = 121;
    localparam int CNT_W        = $clog2(number_image);

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } load_state_t;

endpackage

// File: rtl/frame_slot_decoder.sv
// Slot-write decoder for the frame loader.
// Turns the slot index of an accepted beat into one-hot write enables.
//   wr_en   in   a beat is being stored this cycle
//   idx     in   destination slot index
//   pix_en  out  one-hot pixel slot enable, bit i selects pixel slot i
//   wgt_en  out  one-hot weight bit enable, slot i maps to bit number_image-1-i
module frame_slot_decoder #(
    parameter int number_image = neuron_frame_loader_pkg::number_image,
    parameter int CNT_W        = $clog2(number_image)
) (
    input  logic                    wr_en,
    input  logic [CNT_W-1:0]        idx,
    output logic [number_image-1:0] pix_en,
    output logic [number_image-1:0] wgt_en
);

    for (genvar i = 0; i < number_image; i++) begin : g_slot
        assign pix_en[i] = wr_en && (idx == CNT_W'(i));
        // Weight vector is stored reversed: first beat lands in the MSB.
        assign wgt_en[number_image-1-i] = pix_en[i];
    end

endmodule

// File: rtl/neuron_frame_loader.sv
// Serial-to-parallel frame loader feeding the binary-weighted neuron.
// Collects one signed pixel and one weight bit per accepted beat, then
// presents the complete frame with a valid/ready handshake, frozen until it
// is consumed.
//   clk, rst      clock, synchronous active-high reset
//   in_valid/in_ready/in_pixel/in_weight/in_sof  beat input handshake
//   Image         packed frame, pixel i at [size_word*(i+1)-1 : size_word*i]
//   Weight        weight of pixel i at bit number_image-1-i
//   frame_valid/frame_ready  frame output handshake
//   beat_count    beats stored in the current frame
//   frame_drop    one-cycle pulse when a partial frame is discarded
module neuron_frame_loader #(
    parameter int   size_word    = neuron_frame_loader_pkg::size_word,
    parameter int   number_image = neuron_frame_loader_pkg::number_image,
    localparam int  CNT_W        = $clog2(number_image)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [size_word-1:0]              in_pixel,
    input  logic                              in_weight,
    input  logic                              in_sof,
    output logic [size_word*number_image-1:0] Image,
    output logic [number_image-1:0]           Weight,
    output logic                              frame_valid,
    input  logic                              frame_ready,
    output logic [CNT_W-1:0]                  beat_count,
    output logic                              frame_drop
);

    import neuron_frame_loader_pkg::*;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(number_image - 1);

    load_state_t             state;
    logic                    accept;
    logic [CNT_W-1:0]        idx;
    logic [number_image-1:0] pix_en;
    logic [number_image-1:0] wgt_en;

    // Handshake outputs are pure decodes of the state register.
    assign in_ready    = (state == LOAD);
    assign frame_valid = (state == FULL);

    assign accept = in_valid && (state == LOAD);
    // A start-of-frame beat always restarts at slot 0.
    assign idx    = in_sof ? '0 : beat_count;

    frame_slot_decoder #(
        .number_image (number_image),
        .CNT_W        (CNT_W)
    ) u_dec (
        .wr_en  (accept),
        .idx    (idx),
        .pix_en (pix_en),
        .wgt_en (wgt_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            beat_count <= '0;
            frame_drop <= 1'b0;
            Image      <= '0;
            Weight     <= '0;
        end else begin
            frame_drop <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        for (int i = 0; i < number_image; i++) begin
                            if (pix_en[i]) Image[i*size_word +: size_word] <= in_pixel;
                        end
                        Weight <= (Weight & ~wgt_en) | (wgt_en & {number_image{in_weight}});
                        // Resync mid-frame: the partial frame is abandoned.
                        frame_drop <= in_sof && (beat_count != '0);
                        if (idx == LAST_IDX) begin
                            state      <= FULL;
                            beat_count <= '0;
                        end else begin
                            beat_count <= idx + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (frame_ready) state <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_frame_loader.sv
// Self-checking bench for neuron_frame_loader with a queue-based frame model.
module tb_neuron_frame_loader;

    localparam int SW = 8;
    localparam int N  = 121;
    localparam int IW = SW * N;
    localparam int CW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_pixel;
    logic          in_weight;
    logic          in_sof;
    logic [IW-1:0] Image;
    logic [N-1:0]  Weight;
    logic          frame_valid;
    logic          frame_ready;
    logic [CW-1:0] beat_count;
    logic          frame_drop;

    neuron_frame_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pixel    (in_pixel),
        .in_weight   (in_weight),
        .in_sof      (in_sof),
        .Image       (Image),
        .Weight      (Weight),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .beat_count  (beat_count),
        .frame_drop  (frame_drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the beats of the current frame in arrival order, and
    // the completed frames waiting to be presented.
    logic [SW-1:0] mq_pix[$];
    logic          mq_w[$];
    logic [IW-1:0] exp_img_q[$];
    logic [N-1:0]  exp_w_q[$];
    logic          exp_drop;
    logic [IW-1:0] e_img;
    logic [N-1:0]  e_w;

    function automatic int first_diff(input logic [IW-1:0] a, input logic [IW-1:0] b);
        for (int i = 0; i < N; i++)
            if (a[i*SW +: SW] !== b[i*SW +: SW]) return i;
        return -1;
    endfunction

    task automatic model_clear();
        mq_pix.delete(); mq_w.delete();
        exp_img_q.delete(); exp_w_q.delete();
        exp_drop = 1'b0;
    endtask

    task automatic model_push(input logic [SW-1:0] p, input logic w, input logic sof);
        logic [IW-1:0] fi;
        logic [N-1:0]  fw;
        exp_drop = 1'b0;
        if (sof && mq_pix.size() != 0) begin
            exp_drop = 1'b1;
            mq_pix.delete(); mq_w.delete();
        end
        mq_pix.push_back(p);
        mq_w.push_back(w);
        if (mq_pix.size() == N) begin
            for (int i = 0; i < N; i++) begin
                fi[i*SW +: SW] = mq_pix[i];
                fw[N-1-i]      = mq_w[i];
            end
            exp_img_q.push_back(fi);
            exp_w_q.push_back(fw);
            mq_pix.delete(); mq_w.delete();
        end
    endtask

    // Offer one beat for one edge; the model takes it only if the loader was ready.
    task automatic beat(input logic [SW-1:0] p, input logic w, input logic sof);
        logic rdy;
        in_valid = 1'b1; in_pixel = p; in_weight = w; in_sof = sof;
        rdy = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
        if (rdy) model_push(p, w, sof);
        else exp_drop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic consume();
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
    endtask

    task automatic pop_exp();
        checks++;
        if (exp_img_q.size() == 0) begin
            errors++; $display("FAIL model_frame act none exp one completed frame");
            e_img = '0; e_w = '0;
        end else begin
            e_img = exp_img_q.pop_front();
            e_w   = exp_w_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_pixel = '0; in_weight = 1'b0; in_sof = 1'b0; frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        model_clear();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready act %b exp 1", in_ready); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid act %b exp 0", frame_valid); end
        checks++; if (beat_count !== '0) begin errors++; $display("FAIL reset_beat_count act %0d exp 0", beat_count); end
        checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL reset_frame_drop act %b exp 0", frame_drop); end
        checks++; if (Image !== '0) begin errors++; $display("FAIL reset_image slot %0d nonzero", first_diff(Image, '0)); end
        checks++; if (Weight !== '0) begin errors++; $display("FAIL reset_weight act %h exp 0", Weight); end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) begin
                checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL ramp_early_valid act %b exp 0", frame_valid); end
                checks++; if (beat_count !== CW'(N - 1)) begin errors++; $display("FAIL ramp_count act %0d exp %0d", beat_count, N - 1); end
            end
            beat(SW'(i - 60), (i % 2) == 0, i == 0);
        end
        pop_exp();
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ramp_valid act %b exp 1", frame_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ramp_in_ready act %b exp 0", in_ready); end
        checks++; if (Image[7:0] !== 8'hC4) begin errors++; $display("FAIL ramp_pix0 act %h exp c4", Image[7:0]); end
        checks++; if (Image[967:960] !== 8'h3C) begin errors++; $display("FAIL ramp_pix120 act %h exp 3c", Image[967:960]); end
        checks++; if ({Weight[120], Weight[119], Weight[0]} !== 3'b101) begin
            errors++; $display("FAIL ramp_weight_bits act %b%b%b exp 101", Weight[120], Weight[119], Weight[0]); end
        checks++; if (Image !== e_img) begin errors++; $display("FAIL ramp_image slot %0d act %h exp %h",
            first_diff(Image, e_img), Image[first_diff(Image, e_img)*SW +: SW], e_img[first_diff(Image, e_img)*SW +: SW]); end
        checks++; if (Weight !== e_w) begin errors++; $display("FAIL ramp_weight act %h exp %h", Weight, e_w); end
    endtask

    task automatic test_hold();
        logic [IW-1:0] s_img;
        logic [N-1:0]  s_w;
        s_img = Image; s_w = Weight;
        frame_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1; in_pixel = SW'($urandom); in_weight = 1'($urandom); in_sof = 1'($urandom);
            @(posedge clk); #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc %0d act %b exp 0", c, in_ready); end
            checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc %0d act %b exp 1", c, frame_valid); end
            checks++; if (Image !== s_img || Weight !== s_w) begin
                errors++; $display("FAIL hold_frozen cyc %0d image slot %0d changed, weight act %h exp %h", c, first_diff(Image, s_img), Weight, s_w); end
        end
        in_valid = 1'b0; in_sof = 1'b0;
        consume();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready act %b exp 1", in_ready); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid act %b exp 0", frame_valid); end
    endtask

    task automatic test_resync();
        int drops = 0;
        for (int i = 0; i < 50; i++) begin
            beat(SW'($urandom), 1'($urandom), 1'b0);
            if (frame_drop) drops++;
        end
        checks++; if (beat_count !== CW'(50)) begin errors++; $display("FAIL resync_pre_count act %0d exp 50", beat_count); end
        checks++; if (drops != 0) begin errors++; $display("FAIL resync_pre_drops act %0d exp 0", drops); end
        beat(8'h7F, 1'($urandom), 1'b1);
        checks++; if (frame_drop !== exp_drop || exp_drop !== 1'b1) begin
            errors++; $display("FAIL resync_drop act %b exp %b", frame_drop, exp_drop); end
        checks++; if (beat_count !== CW'(mq_pix.size())) begin errors++; $display("FAIL resync_count act %0d exp %0d", beat_count, mq_pix.size()); end
        @(posedge clk); #1;
        checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL resync_drop_width act %b exp 0", frame_drop); end
        drops = 0;
        for (int i = 0; i < N - 1; i++) begin
            beat(SW'($urandom), 1'($urandom), 1'b0);
            if (frame_drop) drops++;
        end
        pop_exp();
        checks++; if (drops != 0) begin errors++; $display("FAIL resync_post_drops act %0d exp 0", drops); end
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL resync_valid act %b exp 1", frame_valid); end
        checks++; if (Image[7:0] !== 8'h7F) begin errors++; $display("FAIL resync_pix0 act %h exp 7f", Image[7:0]); end
        checks++; if (Image !== e_img) begin errors++; $display("FAIL resync_image first bad slot %0d", first_diff(Image, e_img)); end
        checks++; if (Weight !== e_w) begin errors++; $display("FAIL resync_weight act %h exp %h", Weight, e_w); end
        consume();
    endtask

    task automatic test_sof_first();
        do_reset();
        beat(SW'($urandom), 1'($urandom), 1'b1);
        checks++; if (frame_drop !== 1'b0) begin errors++; $display("FAIL sof_first_drop act %b exp 0", frame_drop); end
        checks++; if (beat_count !== CW'(1)) begin errors++; $display("FAIL sof_first_count act %0d exp 1", beat_count); end
        for (int i = 1; i < N; i++) beat(SW'($urandom), 1'($urandom), 1'b0);
        pop_exp();
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL sof_first_valid act %b exp 1", frame_valid); end
        checks++; if (Image !== e_img) begin errors++; $display("FAIL sof_first_image first bad slot %0d", first_diff(Image, e_img)); end
        checks++; if (Weight !== e_w) begin errors++; $display("FAIL sof_first_weight act %h exp %h", Weight, e_w); end
        consume();
    endtask

    task automatic test_reset_mid();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < (pass == 0 ? 80 : N); i++) beat(SW'($urandom | 1), 1'b1, 1'b0);
            if (pass == 1) begin
                checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL rstmid_full act %b exp 1", frame_valid); end
            end
            do_reset();
            checks++; if (beat_count !== '0) begin errors++; $display("FAIL rstmid_count pass %0d act %0d exp 0", pass, beat_count); end
            checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid pass %0d act %b exp 0", pass, frame_valid); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready pass %0d act %b exp 1", pass, in_ready); end
            checks++; if (Image !== '0 || Weight !== '0) begin
                errors++; $display("FAIL rstmid_clear pass %0d image slot %0d weight %h exp 0", pass, first_diff(Image, '0), Weight); end
        end
    endtask

    task automatic test_back_to_back();
        int frames = 0;
        int last_cyc = -1;
        logic rdy;
        frame_ready = 1'b1; in_valid = 1'b1; in_sof = 1'b0;
        for (int c = 0; c < 600 && frames < 3; c++) begin
            in_pixel = SW'($urandom); in_weight = 1'($urandom);
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) model_push(in_pixel, in_weight, 1'b0);
            if (frame_valid) begin
                pop_exp();
                checks++; if (Image !== e_img || Weight !== e_w) begin
                    errors++; $display("FAIL b2b_frame %0d first bad slot %0d weight act %h exp %h", frames, first_diff(Image, e_img), Weight, e_w); end
                if (last_cyc >= 0) begin
                    checks++; if (c - last_cyc != N + 1) begin errors++; $display("FAIL b2b_period act %0d exp %0d", c - last_cyc, N + 1); end
                end
                last_cyc = c;
                frames++;
            end
        end
        in_valid = 1'b0; frame_ready = 1'b0;
        checks++; if (frames != 3) begin errors++; $display("FAIL b2b_frames act %0d exp 3", frames); end
        checks++; if (exp_img_q.size() != 0) begin errors++; $display("FAIL b2b_leftover act %0d exp 0", exp_img_q.size()); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog act timeout exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ramp();
        test_hold();
        test_resync();
        test_sof_first();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_frame_loader.md
# neuron_frame_loader

Serial-to-parallel front end for the binary-weighted neuron. It accepts one signed 8-bit pixel plus one weight bit per handshake beat and assembles a full frame: the packed `Image` bus and the `Weight` vector. It presents the frame with a valid/ready handshake and holds it stable until the neuron side consumes it. It is the writer end of the neuron's `Image`/`Weight` input interface.

## Interface
Parameters:
- `size_word`, 8: pixel width in bits, two's complement.
- `number_image`, 121: pixels per frame.
- `CNT_W`, `$clog2(number_image)`: width of the beat counter (localparam).

Ports:
- `clk`  in  1  Single clock; all logic is on the rising edge.
- `rst`  in  1  Reset is synchronous and active-high.
- `in_valid`  in  1  A beat is offered.
- `in_ready`  out  1  The loader can accept a beat.
- `in_pixel`  in  size_word  Signed pixel value.
- `in_weight`  in  1  Weight bit for this pixel: 1 = +pixel, 0 = −pixel.
- `in_sof`  in  1  Start of frame; sampled only on an accepted beat.
- `Image`  out  size_word*number_image  Packed frame. Pixel i occupies `[size_word*(i+1)-1 : size_word*i]`.
- `Weight`  out  number_image  Weight for pixel i is at bit `number_image-1-i`, so the first beat lands in the MSB.
- `frame_valid`  out  1  The frame is complete and stable.
- `frame_ready`  in  1  The neuron side consumes the frame.
- `beat_count`  out  CNT_W  Number of beats stored in the current frame.
- `frame_drop`  out  1  One-cycle pulse when a partial frame is discarded.

## Operation
- The design has two states, `LOAD` and `FULL`. Both are registered.
- A beat is accepted when `in_valid && in_ready`.
- `in_ready = (state == LOAD)`.
- `frame_valid = (state == FULL)`.
- On an accepted beat in LOAD, with idx = `in_sof ? 0 : beat_count`:
  - the pixel is written to slot idx;
  - `Weight[number_image-1-idx]` gets `in_weight`;
  - `beat_count` becomes idx+1.
- If the accepted beat has idx == number_image-1, the next state is FULL and `beat_count` returns to 0.
- Resync on `in_sof`: an accepted beat with `in_sof=1` while `beat_count != 0` discards the partial frame. That beat restarts the frame at slot 0, and `frame_drop` pulses the following cycle. `in_sof=1` when `beat_count == 0` is normal and produces no pulse.
- Stale slots are not cleared. A frame is only presented after all number_image slots have been rewritten since the last restart.
- In FULL:
  - `Image` and `Weight` are frozen;
  - input beats are refused;
  - when `frame_ready` is high, the next state is LOAD.
- No arithmetic is done here. Pixels are stored bit-exact and are not sign-extended.
- Reset values:
  - state LOAD, so `in_ready=1`;
  - `frame_valid=0`, `frame_drop=0`, `beat_count=0`;
  - `Image=0`, `Weight=0`.
- Reset in the middle of a frame or while in FULL discards everything and returns to the reset values on the next edge.

## Timing
- Last beat accepted at edge t: `frame_valid=1` and `in_ready=0` from t+1.
- Frame consumed at edge t (`frame_valid && frame_ready`): `in_ready=1` and `frame_valid=0` from t+1. The first beat of the next frame can be accepted at t+1.
- Minimum period is number_image+1 cycles per frame: number_image beats plus one consume cycle.
- `frame_ready` held high permanently still costs exactly one FULL cycle per frame.
- `frame_drop` is registered: high for exactly the cycle after the resync beat.
- Outputs depend only on registers. There are no combinational paths from inputs to outputs.
- `in_sof` and `in_pixel` are ignored whenever no beat is accepted.

## Structure
- A shared package holds `size_word`, `number_image`, and the derived `CNT_W`, so that `neuron_out` and this block agree on packing.
- Slot-write decode (idx → one-hot enable for pixel slot and weight bit) is a natural sub-module, `frame_slot_decoder`. Everything else is inline.

## Test plan
- Reset then 121 beats with pixel i = i−60 and alternating weight starting at 1:
  - `frame_valid` rises one cycle after beat 120;
  - `Image[7:0]=8'hC4` (−60);
  - `Image[967:960]=8'h3C` (60);
  - `Weight[120]=1`, `Weight[119]=0`, `Weight[0]=1`.
- Hold `frame_ready=0` for 20 cycles while still driving `in_valid`:
  - `in_ready` stays 0;
  - `Image`/`Weight` stay unchanged;
  - after `frame_ready=1` for one cycle, `in_ready=1` on the next cycle.
- 50 beats, then a beat with `in_sof=1` and pixel 8'h7F:
  - `frame_drop` pulses once;
  - `beat_count=1`;
  - after 120 more beats the frame presents with `Image[7:0]=8'h7F`.
- `in_sof=1` on the first beat after reset: no `frame_drop`, and behaviour is otherwise normal.
- Assert `rst` after 80 beats and again while in FULL: next cycle `beat_count=0`, `frame_valid=0`, `Image=0`, `in_ready=1`.
- Back-to-back frames with `frame_ready` held at 1 and `in_valid` held at 1: a frame is presented every 122 cycles, and no beat is lost or duplicated (check against a scoreboard).
